// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter slice.
package imem_pkg;

  localparam int unsigned AW_DEFAULT         = 20;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  // Which requester owns the read response arriving next cycle.
  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LD_RD = 2'd2
  } owner_t;

  // Counter width able to hold 0..maxVal (at least one bit).
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive fetch grants while the loader is waiting.
module starve_counter
  import imem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ldReq,
  input  logic fetchGnt,
  input  logic ldGnt,
  output logic starved
);

  localparam int unsigned CW = cntWidth(STARVE_MAX);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] count;

  // Clear when the loader is served or stops asking; count fetch wins otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!ldReq || ldGnt) begin
      count <= '0;
    end else if (fetchGnt && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // Count saturates at LIMIT, so equality is the starvation condition.
  assign starved = (count == LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester arbiter (fetch, loader) in front of a single-port IMEM
// with one-cycle read latency.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int unsigned AW         = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [AW-1:0] fetch_rdata_o,
  output logic          fetch_stall_o,
  input  logic          ld_req_i,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [AW-1:0] ld_wdata_i,
  output logic          ld_gnt_o,
  output logic          ld_rvalid_o,
  output logic [AW-1:0] ld_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_wdata_o,
  input  logic [AW-1:0] mem_rdata_i
);

  logic   starved;
  logic   fetchGnt;
  logic   ldGnt;
  owner_t owner;

  starve_counter #(.STARVE_MAX(STARVE_MAX)) uStarve (
    .clk      (clk),
    .rst      (rst),
    .ldReq    (ld_req_i),
    .fetchGnt (fetchGnt),
    .ldGnt    (ldGnt),
    .starved  (starved)
  );

  // Fetch wins unless the waiting loader has hit its starvation limit; an
  // idle loader never blocks fetch, even at STARVE_MAX=0. Reset masks grants.
  always_comb begin
    fetchGnt = rst && fetch_req_i && (!ld_req_i || !starved);
    ldGnt    = rst && ld_req_i && !fetchGnt;
  end

  // Route the granted requester onto the memory port; idle drives zeros.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (fetchGnt) begin
      mem_addr_o = fetch_addr_i;
    end else if (ldGnt) begin
      mem_addr_o  = ld_addr_i;
      mem_we_o    = ld_we_i;
      mem_wdata_o = ld_wdata_i;
    end
  end

  assign fetch_gnt_o   = fetchGnt;
  assign ld_gnt_o      = ldGnt;
  assign fetch_stall_o = fetch_req_i & ~fetchGnt;

  // Owner tag for the response due next cycle; writes expect no response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_IDLE;
    end else if (fetchGnt) begin
      owner <= OWN_FETCH;
    end else if (ldGnt && !ld_we_i) begin
      owner <= OWN_LD_RD;
    end else begin
      owner <= OWN_IDLE;
    end
  end

  // Steer read data to the tagged owner; the other side sees zero.
  always_comb begin
    fetch_rvalid_o = (owner == OWN_FETCH);
    ld_rvalid_o    = (owner == OWN_LD_RD);
    fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
    ld_rdata_o     = ld_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive fetch grants while loader waits; 0 gives loader strict priority.
REQ-002 SHALL have parameter AW, default 20: address/data width.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_req_i  input  1  fetch stage read request.
REQ-006 SHALL have port fetch_addr_i  input  AW  fetch PC.
REQ-007 SHALL have port fetch_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port fetch_rvalid_o  output  1  fetch read data valid.
REQ-009 SHALL have port fetch_rdata_o  output  AW  fetch instruction word.
REQ-010 SHALL have port fetch_stall_o  output  1  fetch request pending but not granted.
REQ-011 SHALL have port ld_req_i  input  1  loader/debug request.
REQ-012 SHALL have port ld_we_i  input  1  loader write (1) or read (0).
REQ-013 SHALL have port ld_addr_i  input  AW  loader address.
REQ-014 SHALL have port ld_wdata_i  input  AW  loader write data.
REQ-015 SHALL have port ld_gnt_o  output  1  loader request accepted.
REQ-016 SHALL have port ld_rvalid_o  output  1  loader read data valid.
REQ-017 SHALL have port ld_rdata_o  output  AW  loader read data.
REQ-018 SHALL have ports mem_addr_o (output AW), mem_we_o (output 1), mem_wdata_o (output AW), mem_rdata_i (input AW) to the single-port synchronous IMEM, read latency 1.

Function
REQ-019 SHALL grant at most one requester per cycle; gnt is combinational from req and state.
REQ-020 SHALL grant fetch when fetch_req_i=1 and starvation count < STARVE_MAX; otherwise loader if ld_req_i=1.
REQ-021 SHALL grant loader when fetch_req_i=0 and ld_req_i=1.
REQ-022 SHALL increment starvation count on each cycle with ld_req_i=1 and fetch granted, saturating at STARVE_MAX; clear it on loader grant or when ld_req_i=0.
REQ-023 SHALL drive mem_* from the granted requester; with no grant: mem_addr_o=0, mem_we_o=0, mem_wdata_o=0.
REQ-024 SHALL register an owner tag (IDLE/FETCH/LD_RD) on each grant; writes record IDLE.
REQ-025 SHALL assert exactly one of fetch_rvalid_o/ld_rvalid_o one cycle after a read grant, per owner tag, with rdata = mem_rdata_i.
REQ-026 SHALL hold non-owner rdata at 0 and never assert rvalid for a loader write.
REQ-027 SHALL set fetch_stall_o = fetch_req_i & ~fetch_gnt_o.
REQ-028 SHALL support back-to-back grants every cycle, alternating owners without bubbles.
REQ-029 SHALL require requesters to hold req/addr/data stable until gnt; arbiter behaviour on early withdrawal is to drop the request without side effect.

Reset
REQ-030 SHALL on rst=0 force owner tag IDLE, starvation count 0, all gnt/rvalid/rdata/mem outputs 0, asynchronously.
REQ-031 SHALL discard any in-flight read response when reset asserts mid-transaction; no rvalid after release for pre-reset grants.
REQ-032 SHALL resume arbitration on the first rising edge after rst deasserts.

Structure
REQ-033 SHALL place owner-tag enum, AW default and STARVE_MAX default in shared package imem_pkg.
REQ-034 SHALL implement the saturating starvation counter as sub-module starve_counter; remainder flat.

Verification
REQ-035 Fetch only, addr 0x00000,0x00004,0x00008 consecutive -> gnt each cycle, fetch_rvalid_o next cycle with matching mem data, no stall.
REQ-036 Fetch and ld continuous, STARVE_MAX=4 -> 4 fetch grants, 1 ld grant, repeat; fetch_stall_o=1 exactly on ld-grant cycles.
REQ-037 Ld write 0x00010<=0xABCDE, then fetch read 0x00010 -> mem_we_o=1 one cycle, fetch_rdata_o=0xABCDE, no ld_rvalid_o.
REQ-038 STARVE_MAX=0, both requesting -> ld granted every cycle, fetch_stall_o=1 throughout.
REQ-039 Fetch read granted, rst=0 next cycle -> fetch_rvalid_o=0, all outputs 0, count 0; first grant resumes after release.
